// File: rtl/tdm_pkg.sv
// Shared types and width helpers for the TDM demultiplexer.
// The TDM_DEMUX_PARITY_EN macro is consumed by the modules that import this package.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  // Bit counter must reach DATA_W when a trailing parity bit is present.
  function automatic int unsigned bit_cnt_w(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int unsigned slot_cnt_w(input int unsigned num_ch);
    return $clog2(num_ch);
  endfunction

  localparam int unsigned BIT_CNT_W  = bit_cnt_w(DATA_W_DEF);
  localparam int unsigned SLOT_CNT_W = slot_cnt_w(NUM_CH_DEF);

endpackage

// File: rtl/tdm_slot_shifter.sv
// Serial-to-parallel slot shifter with bit counter; MSB arrives first.
// With TDM_DEMUX_PARITY_EN each slot carries one trailing even-parity bit.
module tdm_slot_shifter
  import tdm_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_shift,
  input  logic              i_restart,
  input  logic              i_d,
  output logic              o_bit_cnt_zero,
  output logic              o_word_done_c,
`ifdef TDM_DEMUX_PARITY_EN
  output logic              o_parity_ok_c,
`endif
  output logic [DATA_W-1:0] o_word_c
);

  localparam int unsigned BCW = bit_cnt_w(DATA_W);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned LAST_BIT = DATA_W;
`else
  localparam int unsigned LAST_BIT = DATA_W - 1;
`endif

  logic [BCW-1:0]    r_cnt;
  logic [BCW-1:0]    w_cnt_eff;
  logic              w_last;
  logic [DATA_W-1:0] w_word;

  // A restart treats the current bit as bit 0 regardless of the count.
  assign w_cnt_eff      = i_restart ? '0 : r_cnt;
  assign w_last         = (w_cnt_eff == BCW'(LAST_BIT));
  assign o_word_done_c  = i_shift && w_last;
  assign o_bit_cnt_zero = (r_cnt == '0);
  assign o_word_c       = w_word;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_shift) begin
      r_cnt <= w_last ? '0 : (w_cnt_eff + BCW'(1));
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic [DATA_W-1:0] r_sreg;
  logic              r_par;

  // Data is complete before the parity bit arrives; parity bit is not shifted in.
  assign w_word        = r_sreg;
  assign o_parity_ok_c = ~(r_par ^ i_d);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sreg <= '0;
      r_par  <= 1'b0;
    end else if (i_shift && !w_last) begin
      r_sreg <= {r_sreg[DATA_W-2:0], i_d};
      r_par  <= (w_cnt_eff == '0) ? i_d : (r_par ^ i_d);
    end
  end
`else
  logic [DATA_W-2:0] r_sreg;

  // Final bit completes the word combinationally so it can be stored on the same edge.
  assign w_word = {r_sreg, i_d};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sreg <= '0;
    end else if (i_shift) begin
      r_sreg <= w_word[DATA_W-2:0];
    end
  end
`endif

endmodule

// File: rtl/tdm_demux.sv
// TDM frame demultiplexer: hunts for frame sync, stages slot words, publishes whole frames.
// Optional trailing per-slot parity check enabled by TDM_DEMUX_PARITY_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     bit_en,
  input  logic                     d,
  input  logic                     sync,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     frame_valid,
  output logic                     locked,
  output logic                     sync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int unsigned SCW = slot_cnt_w(NUM_CH);

  tdm_state_e                r_state;
  logic [SCW-1:0]            r_slot;
  logic [DATA_W-1:0]         r_staging [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]  r_ch_data;
  logic                      r_frame_valid;
  logic                      r_sync_err;

  logic                      w_bit_cnt_zero;
  logic                      w_word_done;
  logic [DATA_W-1:0]         w_word;
  logic                      w_at_frame_pos;
  logic                      w_resync;
  logic                      w_lost;
  logic                      w_shift;
  logic                      w_restart;
  logic [NUM_CH*DATA_W-1:0]  w_frame;

  assign w_at_frame_pos = (r_slot == '0) && w_bit_cnt_zero;
  assign w_resync       = (r_state == RECV) && sync && !w_at_frame_pos;
  assign w_lost         = (r_state == RECV) && !sync && w_at_frame_pos;
  assign w_shift        = bit_en && (((r_state == HUNT) && sync) || ((r_state == RECV) && !w_lost));
  assign w_restart      = (r_state == HUNT) || sync;

`ifdef TDM_DEMUX_PARITY_EN
  logic w_parity_ok;
  logic r_parity_err;
  assign parity_err = r_parity_err;
`endif

  tdm_slot_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clock          (clock),
    .resetn         (resetn),
    .i_shift        (w_shift),
    .i_restart      (w_restart),
    .i_d            (d),
    .o_bit_cnt_zero (w_bit_cnt_zero),
    .o_word_done_c  (w_word_done),
`ifdef TDM_DEMUX_PARITY_EN
    .o_parity_ok_c  (w_parity_ok),
`endif
    .o_word_c       (w_word)
  );

  // Completed frame: staged slots plus the word finishing on this edge in the last slot.
  always_comb begin
    w_frame = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_frame[k*DATA_W +: DATA_W] = (k == NUM_CH - 1) ? w_word : r_staging[k];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state       <= HUNT;
      r_slot        <= '0;
      r_ch_data     <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) r_staging[k] <= '0;
`ifdef TDM_DEMUX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
      if (bit_en) begin
        case (r_state)
          HUNT: begin
            if (sync) begin
              r_state <= RECV;
              r_slot  <= '0;
            end
          end
          RECV: begin
            if (w_resync) begin
              r_sync_err <= 1'b1;
              r_slot     <= '0;
              for (int unsigned k = 0; k < NUM_CH; k++) r_staging[k] <= '0;
            end else if (w_lost) begin
              r_sync_err <= 1'b1;
              r_state    <= HUNT;
            end else if (w_word_done) begin
              r_staging[r_slot] <= w_word;
`ifdef TDM_DEMUX_PARITY_EN
              if (!w_parity_ok) r_parity_err <= 1'b1;
`endif
              if (r_slot == SCW'(NUM_CH - 1)) begin
                r_slot        <= '0;
                r_ch_data     <= w_frame;
                r_frame_valid <= 1'b1;
              end else begin
                r_slot <= r_slot + SCW'(1);
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign ch_data     = r_ch_data;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = (r_state == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (NUM_CH=4, DATA_W=8, bit strobe every 2nd clock).
// Parity scenario runs only when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux;

  logic        clock = 1'b0;
  logic        resetn;
  logic        bit_en;
  logic        d;
  logic        sync;
  logic [31:0] ch_data;
  logic        frame_valid;
  logic        locked;
  logic        sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic        parity_err;
  int          pe_count;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fv_count, se_count;
  int fv_cyc_last, fv_cyc_prev;

  tdm_demux #(.NUM_CH(4), .DATA_W(8)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bit_en      (bit_en),
    .d           (d),
    .sync        (sync),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .locked      (locked),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .sync_err    (sync_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    fv_count = 0;
    se_count = 0;
    fv_cyc_last = -1;
    fv_cyc_prev = -1;
`ifdef TDM_DEMUX_PARITY_EN
    pe_count = 0;
`endif
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic en, input logic dd, input logic ss);
    @(negedge clock);
    bit_en = en;
    d      = dd;
    sync   = ss;
    @(posedge clock);
    #1;
    if (frame_valid === 1'b1) begin
      fv_count++;
      fv_cyc_prev = fv_cyc_last;
      fv_cyc_last = cyc;
    end
    if (sync_err === 1'b1) se_count++;
`ifdef TDM_DEMUX_PARITY_EN
    if (parity_err === 1'b1) pe_count++;
`endif
  endtask

  task automatic send_bit(input logic dd, input logic ss);
    step(1'b1, dd, ss);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input logic first_sync);
    for (int i = 7; i >= 0; i--) send_bit(w[i], first_sync && (i == 7));
`ifdef TDM_DEMUX_PARITY_EN
    send_bit(^w, 1'b0);
`endif
  endtask

  task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
    send_word(w0, 1'b1);
    send_word(w1, 1'b0);
    send_word(w2, 1'b0);
    send_word(w3, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    bit_en = 1'b0;
    d      = 1'b0;
    sync   = 1'b0;
    clear_counts();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("reset_ch_data", ch_data, 32'h0);
    check("reset_frame_valid", 32'(frame_valid), 32'h0);
    check("reset_locked", 32'(locked), 32'h0);
    check("reset_sync_err", 32'(sync_err), 32'h0);
    resetn = 1'b1;

    // 1: single frame; output must not move before the final bit
    clear_counts();
    send_word(8'hA5, 1'b1);
    send_word(8'h3C, 1'b0);
    send_word(8'hFF, 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h01 >> i), 1'b0);
    check("t1_ch_data_before_last_bit", ch_data, 32'h0);
    check("t1_fv_before_last_bit", 32'(fv_count), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("t1_frame_valid_pulse", 32'(frame_valid), 32'h1);
    check("t1_ch_data", ch_data, 32'h01FF3CA5);
    step(1'b0, 1'b0, 1'b0);
    check("t1_frame_valid_one_cycle", 32'(frame_valid), 32'h0);
    check("t1_locked", 32'(locked), 32'h1);
    check("t1_fv_count", 32'(fv_count), 32'd1);
    check("t1_sync_err_count", 32'(se_count), 32'd0);

    // 2: back-to-back frames, sync on the bit right after frame end
    clear_counts();
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
    send_frame(8'h12, 8'h34, 8'h56, 8'h78);
    check("t2_fv_count", 32'(fv_count), 32'd2);
    check("t2_fv_spacing_clocks", 32'(fv_cyc_last - fv_cyc_prev), 32'd64);
    check("t2_ch_data", ch_data, 32'h78563412);
    check("t2_sync_err_count", 32'(se_count), 32'd0);

    // 3: sync at slot 2 bit 3 restarts the frame
    clear_counts();
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("t3_sync_err_pulse", 32'(sync_err), 32'h1);
    check("t3_ch_data_held", ch_data, 32'h78563412);
    check("t3_locked_after_resync", 32'(locked), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("t3_sync_err_one_cycle", 32'(sync_err), 32'h0);
    for (int i = 6; i >= 0; i--) send_bit(1'(8'h11 >> i), 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    check("t3_fv_count", 32'(fv_count), 32'd1);
    check("t3_ch_data", ch_data, 32'h44332211);
    check("t3_sync_err_count", 32'(se_count), 32'd1);

    // 4: missing sync at frame position drops lock; bits ignored until next sync
    clear_counts();
    step(1'b1, 1'b1, 1'b0);
    check("t4_sync_err_pulse", 32'(sync_err), 32'h1);
    check("t4_unlocked", 32'(locked), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'b1, 1'b0);
    check("t4_still_unlocked", 32'(locked), 32'h0);
    check("t4_no_frame_in_hunt", 32'(fv_count), 32'd0);
    check("t4_ch_data_held", ch_data, 32'h44332211);
    check("t4_single_sync_err", 32'(se_count), 32'd1);
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
    check("t4_relock_ch_data", ch_data, 32'h01FF3CA5);
    check("t4_relock_fv_count", 32'(fv_count), 32'd1);

    // 5: one-edge reset mid-frame
    clear_counts();
    send_word(8'hC3, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    resetn = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    resetn = 1'b1;
    check("t5_reset_ch_data", ch_data, 32'h0);
    check("t5_reset_locked", 32'(locked), 32'h0);
    check("t5_reset_frame_valid", 32'(frame_valid), 32'h0);
    check("t5_reset_sync_err", 32'(sync_err), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    send_frame(8'h12, 8'h34, 8'h56, 8'h78);
    check("t5_ch_data_after_reset", ch_data, 32'h78563412);
    check("t5_fv_count", 32'(fv_count), 32'd1);
    check("t5_sync_err_count", 32'(se_count), 32'd0);

`ifdef TDM_DEMUX_PARITY_EN
    // 6: bad parity on slot 1 still stores the word and completes the frame
    clear_counts();
    send_word(8'h5A, 1'b1);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h3C >> i), 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t6_parity_err_pulse", 32'(parity_err), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    send_word(8'h77, 1'b0);
    send_word(8'h80, 1'b0);
    check("t6_parity_err_count", 32'(pe_count), 32'd1);
    check("t6_fv_count", 32'(fv_count), 32'd1);
    check("t6_ch_data", ch_data, 32'h80773C5A);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
